ft245_fifo_emulator: RTL and testbench

//  Device-side emulation of the FT245BM parallel FIFO. Lets the JTAG bit-bang/byte-shift engine run with no external USB chip.

---
 rtl/ft245_fifo_emulator.sv | 226 ++++++++++++++++++++++
 tb/tb_ft245_fifo_emulator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_fifo_emulator.sv
// Device-side stand-in for an FT245BM parallel FIFO: host byte streams on valid/ready,
// engine side on nRXF/nRD/nTXE/WR with registered flags and pad data out/enable.
module ft245_fifo_emulator #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16,
    parameter int RXF_GAP  = 2,
    parameter int TXE_GAP  = 2
) (
    input  logic       CLK,
    input  logic       nRST_ASYNC,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       nRXF,
    output logic       nTXE,
    input  logic       nRD,
    input  logic       WR,
    input  logic [7:0] D_I,
    output logic [7:0] D_O,
    output logic       D_OE,
    output logic       rx_underflow,
    output logic       tx_overflow
);

    // Host handshakes: a byte moves on every CLK edge where valid and ready are both high;
    // valid never waits on ready, and ready may depend only on FIFO occupancy.

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_ONE = 1;
    localparam logic [TX_AW:0] TX_ONE = 1;
    localparam logic [7:0] RX_GAP_LOAD = 8'(RXF_GAP - 1);
    localparam logic [7:0] TX_GAP_LOAD = 8'(TXE_GAP - 1);

    typedef enum logic [1:0] {RX_EMPTY, RX_AVAIL, RX_READ, RX_GAP} rx_state_t;
    typedef enum logic [1:0] {TX_OPEN, TX_WRITE, TX_GAP, TX_FULL} tx_state_t;

    logic nrd_q, wr_q, alive_q;
    logic rd_fall, rd_rise, wr_fall;

    always_ff @(posedge CLK or negedge nRST_ASYNC) begin
        if (!nRST_ASYNC) begin
            nrd_q   <= 1'b1;
            wr_q    <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            nrd_q   <= nRD;
            wr_q    <= WR;
            alive_q <= 1'b1;
        end
    end

    assign rd_fall = nrd_q & ~nRD;
    assign rd_rise = ~nrd_q & nRD;
    assign wr_fall = wr_q & ~WR;

    // ---------------- RX FIFO (host -> engine) ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wptr, rx_rptr, rx_count;
    logic           rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]     rx_head;

    assign rx_count = rx_wptr - rx_rptr;
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                      (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
    assign rx_ready = alive_q & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_head  = rx_mem[rx_rptr[RX_AW-1:0]];

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_data;
    end

    always_ff @(posedge CLK or negedge nRST_ASYNC) begin
        if (!nRST_ASYNC) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RX_ONE;
            if (rx_pop)  rx_rptr <= rx_rptr + RX_ONE;
        end
    end

    // ---------------- TX FIFO (engine -> host) ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wptr, tx_rptr;
    logic           tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]     tx_hold;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
    assign tx_valid = ~tx_empty;
    assign tx_data  = tx_mem[tx_rptr[TX_AW-1:0]];
    assign tx_pop   = tx_valid & tx_ready;
    assign tx_push  = wr_fall & ~tx_full;

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wptr[TX_AW-1:0]] <= tx_hold;
    end

    // The engine releases D in the cycle WR drops, so the last byte seen with WR high is kept.
    always_ff @(posedge CLK or negedge nRST_ASYNC) begin
        if (!nRST_ASYNC) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            tx_hold <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TX_ONE;
            if (tx_pop)  tx_rptr <= tx_rptr + TX_ONE;
            if (WR)      tx_hold <= D_I;
        end
    end

    // ---------------- RX FSM ----------------
    rx_state_t  rx_state, rx_state_d;
    logic [7:0] rx_gap, rx_gap_d;
    logic       nrxf_d, d_oe_d, rx_uf_d, rx_uf_start;
    logic [7:0] d_o_d;

    always_ff @(posedge CLK or negedge nRST_ASYNC) begin
        if (!nRST_ASYNC) begin
            rx_state     <= RX_EMPTY;
            rx_gap       <= '0;
            nRXF         <= 1'b1;
            D_O          <= '0;
            D_OE         <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            rx_state     <= rx_state_d;
            rx_gap       <= rx_gap_d;
            nRXF         <= nrxf_d;
            D_O          <= d_o_d;
            D_OE         <= d_oe_d;
            rx_underflow <= rx_uf_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state;
        rx_gap_d   = rx_gap;
        unique case (rx_state)
            RX_EMPTY: if (!rx_empty) rx_state_d = RX_AVAIL;
            RX_AVAIL: if (rd_fall)   rx_state_d = RX_READ;
            RX_READ: begin
                if (rd_rise) begin
                    rx_state_d = RX_GAP;
                    rx_gap_d   = RX_GAP_LOAD;
                end
            end
            RX_GAP: begin
                if (rx_gap == '0) rx_state_d = rx_empty ? RX_EMPTY : RX_AVAIL;
                else              rx_gap_d   = rx_gap - 8'd1;
            end
            default: rx_state_d = RX_EMPTY;
        endcase
    end

    // nRXF goes high at the start of a read: the engine sees it through a slow synchronizer.
    always_comb begin
        nrxf_d      = (rx_state_d != RX_AVAIL);
        rx_pop      = (rx_state == RX_READ) & rd_rise;
        rx_uf_start = rd_fall & ((rx_state == RX_EMPTY) | (rx_state == RX_GAP));
        rx_uf_d     = rx_underflow | rx_uf_start;
        d_o_d       = D_O;
        d_oe_d      = D_OE;
        if ((rx_state == RX_AVAIL) && rd_fall) begin
            d_o_d  = rx_head;
            d_oe_d = 1'b1;
        end else if (rx_uf_start) begin
            d_o_d  = 8'hFF;
            d_oe_d = 1'b1;
        end else if (rd_rise) begin
            d_oe_d = 1'b0;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t  tx_state, tx_state_d;
    logic [7:0] tx_gap, tx_gap_d;
    logic       ntxe_d, tx_ovf_d;

    always_ff @(posedge CLK or negedge nRST_ASYNC) begin
        if (!nRST_ASYNC) begin
            tx_state    <= TX_OPEN;
            tx_gap      <= '0;
            nTXE        <= 1'b1;
            tx_overflow <= 1'b0;
        end else begin
            tx_state    <= tx_state_d;
            tx_gap      <= tx_gap_d;
            nTXE        <= ntxe_d;
            tx_overflow <= tx_ovf_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state;
        tx_gap_d   = tx_gap;
        unique case (tx_state)
            TX_OPEN:  if (WR) tx_state_d = TX_WRITE;
            TX_WRITE: begin
                if (wr_fall) begin
                    tx_state_d = TX_GAP;
                    tx_gap_d   = TX_GAP_LOAD;
                end
            end
            TX_GAP: begin
                if (tx_gap == '0) tx_state_d = tx_full ? TX_FULL : TX_OPEN;
                else              tx_gap_d   = tx_gap - 8'd1;
            end
            TX_FULL:  if (!tx_full) tx_state_d = TX_OPEN;
            default:  tx_state_d = TX_OPEN;
        endcase
    end

    always_comb begin
        ntxe_d   = (tx_state_d != TX_OPEN);
        tx_ovf_d = tx_overflow | (wr_fall & tx_full);
    end

endmodule

// File: tb/tb_ft245_fifo_emulator.sv
// Directed bench for ft245_fifo_emulator: host streams, engine strobes, gaps, wrap,
// overflow/underflow and asynchronous reset, all against hand-computed values.
module tb_ft245_fifo_emulator;

    logic       CLK = 1'b0;
    logic       nRST_ASYNC = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       nRXF, nTXE;
    logic       nRD = 1'b1;
    logic       WR = 1'b0;
    logic [7:0] D_I = '0;
    logic [7:0] D_O;
    logic       D_OE;
    logic       rx_underflow, tx_overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    ft245_fifo_emulator dut (
        .CLK(CLK), .nRST_ASYNC(nRST_ASYNC),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .nRXF(nRXF), .nTXE(nTXE), .nRD(nRD), .WR(WR),
        .D_I(D_I), .D_O(D_O), .D_OE(D_OE),
        .rx_underflow(rx_underflow), .tx_overflow(tx_overflow)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic host_push(input logic [7:0] v);
        rx_valid = 1'b1;
        rx_data  = v;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_nrxf_low();
        int n = 0;
        while (nRXF !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("wait_nrxf", 8'(nRXF), 8'h00);
    endtask

    task automatic wait_ntxe_low();
        int n = 0;
        while (nTXE !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        check("wait_ntxe", 8'(nTXE), 8'h00);
    endtask

    // nRD low for three sampled edges; data is taken the cycle after the fall.
    task automatic engine_read(output logic [7:0] v);
        wait_nrxf_low();
        nRD = 1'b0;
        tick();
        v = D_O;
        check("rd_d_oe", 8'(D_OE), 8'h01);
        tick(2);
        nRD = 1'b1;
        tick();
    endtask

    task automatic engine_write_force(input logic [7:0] v);
        D_I = v;
        WR  = 1'b1;
        tick(2);
        WR  = 1'b0;
        D_I = ~v;
        tick();
    endtask

    task automatic engine_write(input logic [7:0] v);
        wait_ntxe_low();
        engine_write_force(v);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        // Reset state
        #1 nRST_ASYNC = 1'b0;
        tick(2);
        check("rst_nrxf", 8'(nRXF), 8'h01);
        check("rst_ntxe", 8'(nTXE), 8'h01);
        check("rst_d_oe", 8'(D_OE), 8'h00);
        check("rst_d_o", D_O, 8'h00);
        check("rst_rx_ready", 8'(rx_ready), 8'h00);
        check("rst_tx_valid", 8'(tx_valid), 8'h00);
        check("rst_flags", {6'b0, rx_underflow, tx_overflow}, 8'h00);
        nRST_ASYNC = 1'b1;
        tick();
        check("post_rst_rx_ready", 8'(rx_ready), 8'h01);
        check("post_rst_ntxe", 8'(nTXE), 8'h00);

        // T1: host byte latency and FT245 read timing
        host_push(8'hA5);
        check("t1_nrxf_t1", 8'(nRXF), 8'h01);
        host_push(8'h5A);
        check("t1_nrxf_t2", 8'(nRXF), 8'h00);
        nRD = 1'b0;
        tick();
        check("t1_d_o", D_O, 8'hA5);
        check("t1_d_oe", 8'(D_OE), 8'h01);
        check("t1_nrxf_read", 8'(nRXF), 8'h01);
        tick(2);
        nRD = 1'b1;
        tick();
        check("t1_d_oe_off", 8'(D_OE), 8'h00);
        check("t1_gap0", 8'(nRXF), 8'h01);
        tick();
        check("t1_gap1", 8'(nRXF), 8'h01);
        tick();
        check("t1_nrxf_again", 8'(nRXF), 8'h00);
        engine_read(b);
        check("t1_second", b, 8'h5A);

        // T2: engine write, host sees it one cycle after WR falls
        D_I = 8'h3C;
        WR  = 1'b1;
        tick();
        check("t2_ntxe_busy", 8'(nTXE), 8'h01);
        tick();
        WR  = 1'b0;
        D_I = 8'h00;
        tick();
        check("t2_tx_valid", 8'(tx_valid), 8'h01);
        check("t2_tx_data", tx_data, 8'h3C);
        tick();
        check("t2_gap", 8'(nTXE), 8'h01);
        tick();
        check("t2_ntxe_open", 8'(nTXE), 8'h00);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("t2_drained", 8'(tx_valid), 8'h00);

        // T3: two full RX fills, second one wraps the pointers
        for (int pass = 0; pass < 2; pass++) begin
            rx_valid = 1'b1;
            for (int i = 0; i < 16; i++) begin
                rx_data = 8'(pass * 16 + i);
                exp_q.push_back(8'(pass * 16 + i));
                tick();
            end
            rx_valid = 1'b0;
            check("t3_full_rx_ready", 8'(rx_ready), 8'h00);
            for (int i = 0; i < 16; i++) begin
                engine_read(b);
                check("t3_order", b, exp_q.pop_front());
            end
            check("t3_drained_rx_ready", 8'(rx_ready), 8'h01);
        end

        // T4: 16 writes fill TX, forced 17th is dropped
        for (int i = 0; i < 16; i++) begin
            engine_write(8'(i));
            exp_q.push_back(8'(i));
        end
        tick(8);
        check("t4_ntxe_full", 8'(nTXE), 8'h01);
        check("t4_no_ovf_yet", 8'(tx_overflow), 8'h00);
        engine_write_force(8'hEE);
        check("t4_overflow", 8'(tx_overflow), 8'h01);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t4_tx_valid", 8'(tx_valid), 8'h01);
            check("t4_tx_data", tx_data, exp_q.pop_front());
            tick();
        end
        tx_ready = 1'b0;
        check("t4_empty", 8'(tx_valid), 8'h00);
        tick(3);
        check("t4_ntxe_reopen", 8'(nTXE), 8'h00);

        // T5: simultaneous push/pop at count 4, then underflow read
        for (int i = 0; i < 4; i++) host_push(8'h40 + 8'(i));
        wait_nrxf_low();
        check("t5_count4", 8'(dut.rx_count), 8'h04);
        nRD = 1'b0;
        tick();
        check("t5_head", D_O, 8'h40);
        tick();
        nRD      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        tick();
        rx_valid = 1'b0;
        check("t5_count_same", 8'(dut.rx_count), 8'h04);
        for (int i = 1; i < 5; i++) begin
            engine_read(b);
            check("t5_order", b, 8'h40 + 8'(i));
        end
        tick(5);
        check("t5_empty", 8'(dut.rx_count), 8'h00);
        nRD = 1'b0;
        tick();
        check("t5_uf_d_o", D_O, 8'hFF);
        check("t5_uf_d_oe", 8'(D_OE), 8'h01);
        check("t5_underflow", 8'(rx_underflow), 8'h01);
        nRD = 1'b1;
        tick();
        check("t5_uf_release", 8'(D_OE), 8'h00);
        check("t5_uf_nrxf", 8'(nRXF), 8'h01);
        check("t5_uf_sticky", 8'(rx_underflow), 8'h01);

        // T6: asynchronous reset in the middle of a read
        engine_write(8'h77);
        host_push(8'h99);
        wait_nrxf_low();
        nRD = 1'b0;
        tick();
        check("t6_d_oe_pre", 8'(D_OE), 8'h01);
        #2 nRST_ASYNC = 1'b0;
        #1;
        check("t6_d_oe", 8'(D_OE), 8'h00);
        check("t6_nrxf", 8'(nRXF), 8'h01);
        check("t6_ntxe", 8'(nTXE), 8'h01);
        check("t6_tx_valid", 8'(tx_valid), 8'h00);
        check("t6_flags", {6'b0, rx_underflow, tx_overflow}, 8'h00);
        nRD = 1'b1;
        tick(2);
        nRST_ASYNC = 1'b1;
        tick();
        check("t6_rx_ready", 8'(rx_ready), 8'h01);
        check("t6_rx_count", 8'(dut.rx_count), 8'h00);
        tick(3);
        check("t6_nrxf_idle", 8'(nRXF), 8'h01);
        check("t6_tx_empty", 8'(tx_valid), 8'h00);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
